// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative RV32M multiply/divide unit. It runs one shift-add
//             (multiply) or one restoring shift-subtract (divide) step per
//             cycle on operand magnitudes. A FIX cycle then applies the result
//             signs, and a DONE cycle presents the result.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             start_ex, funct3_ex      - op request and RV32M funct3
//             src_a, src_b             - operands, sampled only at accept
//             busy, stall, done        - status; stall freezes IF/ID/EX
//             result                   - registered result
//  Config   : `define MULDIV_DIV_EN enables the divide datapath. Without it,
//             ops 4-7 return 0 after FIX/DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_ex,
   input  logic [2:0]  funct3_ex,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [2:0]  op_q;
   logic [31:0] opnd_q;   // multiplicand (MUL) or divisor (DIV) magnitude
   logic [63:0] acc_q;    // product, or {remainder, quotient} for divide
   logic        neg_q;    // product / quotient must be negated in FIX
   logic        done_q;
   logic [31:0] result_q;
`ifdef MULDIV_DIV_EN
   logic        rem_neg_q; // remainder takes the dividend sign
   logic        div0_q;    // divide-by-zero: quotient is all-ones, not negated
`endif

   // Operand sign handling at accept time
   logic        a_signed_d, b_signed_d, a_neg_d, b_neg_d;
   logic [31:0] mag_a_d, mag_b_d;

   always_comb begin
      if (funct3_ex[2]) begin
         a_signed_d = ~funct3_ex[0];           // DIV/REM signed, DIVU/REMU not
         b_signed_d = ~funct3_ex[0];
      end else begin
         a_signed_d = (funct3_ex != 3'd3);     // MUL, MULH, MULHSU
         b_signed_d = (funct3_ex[1] == 1'b0);  // MUL, MULH
      end
      a_neg_d = a_signed_d & src_a[31];
      b_neg_d = b_signed_d & src_b[31];
      mag_a_d = a_neg_d ? (~src_a + 32'd1) : src_a;
      mag_b_d = b_neg_d ? (~src_b + 32'd1) : src_b;
   end

   // Right-shifting multiplier: the multiplier sits in acc_q[31:0] and
   // drains out as the partial product fills acc_q[63:32].
   logic [32:0] mul_sum_d;
   logic [63:0] mul_next_d;
   assign mul_sum_d  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next_d = {mul_sum_d, acc_q[31:1]};

`ifdef MULDIV_DIV_EN
   // Restoring divider: the partial remainder is always below the divisor,
   // so the 33-bit shifted value minus the divisor never wraps when it is
   // non-negative, and bit 32 is a clean borrow flag.
   logic [32:0] div_shift_d, div_diff_d;
   logic [63:0] div_next_d;
   assign div_shift_d = {acc_q[63:32], acc_q[31]};
   assign div_diff_d  = div_shift_d - {1'b0, opnd_q};
   assign div_next_d  = div_diff_d[32] ? {div_shift_d[31:0], acc_q[30:0], 1'b0}
                                       : {div_diff_d[31:0],  acc_q[30:0], 1'b1};
`endif

   // Sign fix-up and result select, used in the FIX state
   logic [63:0] prod_fix_d;
   logic [31:0] fix_res_d;
`ifdef MULDIV_DIV_EN
   logic [31:0] quot_fix_d, rem_fix_d;
`endif

   always_comb begin
      prod_fix_d = neg_q ? (~acc_q + 64'd1) : acc_q;
      fix_res_d  = (op_q == 3'd0) ? prod_fix_d[31:0] : prod_fix_d[63:32];
`ifdef MULDIV_DIV_EN
      quot_fix_d = (neg_q & ~div0_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      rem_fix_d  = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
      if (op_q[2]) begin
         fix_res_d = op_q[1] ? rem_fix_d : quot_fix_d;
      end
`else
      if (op_q[2]) begin
         fix_res_d = 32'h0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         op_q      <= 3'd0;
         opnd_q    <= 32'h0;
         acc_q     <= 64'h0;
         neg_q     <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= 32'h0;
`ifdef MULDIV_DIV_EN
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_ex) begin
                  op_q  <= funct3_ex;
                  cnt_q <= 6'd0;
                  neg_q <= a_neg_d ^ b_neg_d;
                  if (!funct3_ex[2]) begin
                     opnd_q  <= mag_a_d;
                     acc_q   <= {32'h0, mag_b_d};
                     state_q <= S_MUL;
                  end else begin
`ifdef MULDIV_DIV_EN
                     opnd_q    <= mag_b_d;
                     rem_neg_q <= a_neg_d;
                     if (src_b == 32'h0) begin
                        // |a| re-signed by FIX gives back src_a as remainder
                        div0_q  <= 1'b1;
                        acc_q   <= {mag_a_d, 32'hFFFF_FFFF};
                        state_q <= S_FIX;
                     end else begin
                        div0_q  <= 1'b0;
                        acc_q   <= {32'h0, mag_a_d};
                        state_q <= S_DIV;
                     end
`else
                     state_q <= S_FIX;
`endif
                  end
               end
            end
            S_MUL: begin
               acc_q <= mul_next_d;
               if (cnt_q == 6'd31) begin
                  cnt_q   <= 6'd0;
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            S_DIV: begin
`ifdef MULDIV_DIV_EN
               acc_q <= div_next_d;
               if (cnt_q == 6'd31) begin
                  cnt_q   <= 6'd0;
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
`else
               state_q <= S_IDLE;
`endif
            end
            S_FIX: begin
               result_q <= fix_res_d;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;
   // A request in IDLE stalls the pipe immediately; the DONE cycle releases it.
   assign stall  = (start_ex & ~busy) | (busy & ~done_q);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer. It runs directed and
//             random RV32M operations and compares them against an
//             arithmetic reference model. It also covers reset mid-operation,
//             reset priority and a start request held high.
//  Config   : honours `define MULDIV_DIV_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_ex;
   logic [2:0]  funct3_ex;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start_ex  (start_ex),
      .funct3_ex (funct3_ex),
      .src_a     (src_a),
      .src_b     (src_b),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: RV32M results from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      ia = int'(a);
      ib = int'(b);
      p  = 64'h0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
`ifdef MULDIV_DIV_EN
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
`else
         default: return 32'h0;
`endif
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] f, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
      return (f[2] && b == 32'h0) ? 2 : 34;
`else
      return f[2] ? 2 : 34;
`endif
   endfunction

   // One accepted operation. Inputs are scrambled while busy, including
   // spurious start requests, none of which may influence the outcome.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] exp_r;
      int          exp_lat, lat, stall_bad;
      exp_r     = model(f, a, b);
      exp_lat   = model_latency(f, b);
      lat       = 0;
      stall_bad = 0;
      @(negedge clk);
      start_ex  = 1'b1;
      funct3_ex = f;
      src_a     = a;
      src_b     = b;
      #1;
      check({tag, ":stall_k"}, {63'h0, stall}, 64'd1);
      @(posedge clk);
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n;
            if (stall !== 1'b0) stall_bad++;
            check({tag, ":result"}, {32'h0, result}, {32'h0, exp_r});
            start_ex = 1'b0;
         end else begin
            if (stall !== 1'b1 || busy !== 1'b1) stall_bad++;
            start_ex  = 1'($urandom_range(0, 1));
            funct3_ex = 3'($urandom);
            src_a     = $urandom;
            src_b     = $urandom;
         end
      end
      start_ex = 1'b0;
      check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ":stall_busy"}, 64'(stall_bad), 64'd0);
      @(negedge clk);
      check({tag, ":idle_after"}, {62'h0, done, busy}, 64'd0);
      check({tag, ":hold"}, {32'h0, result}, {32'h0, exp_r});
   endtask

   initial begin : main
      int          pulses, first_n, second_n;
      logic [2:0]  f;
      logic [31:0] a, b;

      rst       = 1'b1;
      start_ex  = 1'b0;
      funct3_ex = 3'd0;
      src_a     = 32'h0;
      src_b     = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_state", {30'h0, busy, done, stall, result, 1'b0}, 64'h0);
      rst = 1'b0;

      // Directed cases
      run_op("MUL_7x-3",  3'd0, 32'd7,          32'hFFFF_FFFD);
      run_op("MULHU_ff",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
      run_op("MULH_ff",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
      run_op("MULHSU",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
      run_op("DIV_-7/2",  3'd4, 32'hFFFF_FFF9,  32'd2);
      run_op("REM_-7/2",  3'd6, 32'hFFFF_FFF9,  32'd2);
      run_op("DIVU_/0",   3'd5, 32'd100,        32'd0);
      run_op("REM_/0",    3'd6, 32'hFFFF_FFF9,  32'd0);
      run_op("DIV_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
      run_op("REM_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
      run_op("REMU",      3'd7, 32'hFFFF_FFF0,  32'd7);

      // Reset in the middle of a multiply
      @(negedge clk);
      start_ex  = 1'b1;
      funct3_ex = 3'd0;
      src_a     = 32'd12345;
      src_b     = 32'd678;
      pulses    = 0;
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         start_ex = 1'b0;
         if (done) pulses++;
         if (n == 10) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      if (done) pulses++;
      check("rst_mid:state", {62'h0, busy, done}, 64'd0);
      check("rst_mid:result", {32'h0, result}, 64'h0);
      check("rst_mid:no_done", 64'(pulses), 64'd0);
      run_op("after_rst", 3'd0, 32'd12345, 32'd678);

      // Reset wins over a simultaneous start
      @(negedge clk);
      rst       = 1'b1;
      start_ex  = 1'b1;
      funct3_ex = 3'd3;
      @(negedge clk);
      rst      = 1'b0;
      start_ex = 1'b0;
      check("rst_prio:busy", {63'h0, busy}, 64'd0);

      // Start held high through two operations
      @(negedge clk);
      start_ex  = 1'b1;
      funct3_ex = 3'd0;
      src_a     = 32'd5;
      src_b     = 32'd6;
      pulses    = 0;
      first_n   = 0;
      second_n  = 0;
      @(posedge clk);
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (pulses == 1) first_n = n;
            if (pulses == 2) begin
               second_n = n;
               start_ex = 1'b0;
               check("held:result", {32'h0, result}, 64'd30);
            end
         end
      end
      start_ex = 1'b0;
      check("held:pulses", 64'(pulses), 64'd2);
      check("held:first", 64'(first_n), 64'd34);
      check("held:second", 64'(second_n), 64'd69);

      // Random operations, biased toward the boundary cases
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op("random", f, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: start_ex  input  1  operation request from EX stage, sampled only in IDLE.
REQ-004 SHALL: funct3_ex  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL: src_a  input  32  operand A (dividend / multiplicand).
REQ-006 SHALL: src_b  input  32  operand B (divisor / multiplier).
REQ-007 SHALL: busy  output  1  high in every state except IDLE.
REQ-008 SHALL: stall  output  1  combinational; high when (start_ex in IDLE) or (busy and not done); freezes IF/ID/EX.
REQ-009 SHALL: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL: result  output  32  registered result; holds value until the next accepted start.

Function
REQ-011 SHALL: states are IDLE, MUL, DIV, FIX, DONE.
REQ-012 SHALL: start_ex=1 in IDLE at edge k latches funct3_ex, |src_a|, |src_b| (signedness per op) and operand signs; go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-013 SHALL: MUL does one shift-add per cycle, 32 iterations, on a 64-bit unsigned product of magnitudes; a 6-bit iteration counter starts at 0 and terminal count is 31.
REQ-014 SHALL: DIV does one restoring shift-subtract per cycle, 32 iterations, producing unsigned quotient and remainder of magnitudes.
REQ-015 SHALL: after the last iteration go to FIX (negate product if signs differ for signed ops; quotient negated if dividend and divisor signs differ; remainder takes dividend sign); then DONE.
REQ-016 SHALL: normal latency: iterations in cycles k+1..k+32, FIX at k+33, DONE (done=1, result valid) at k+34, IDLE at k+35.
REQ-017 SHALL: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32]; DIV/DIVU quotient; REM/REMU remainder.
REQ-018 SHALL: divisor 0 skips DIV: IDLE->FIX->DONE, done at k+2; quotient 32'hFFFF_FFFF, remainder = src_a.
REQ-019 SHALL: signed overflow (src_a 32'h8000_0000, src_b 32'hFFFF_FFFF, DIV/REM) returns quotient 32'h8000_0000, remainder 0 at normal latency.
REQ-020 SHALL: start_ex while busy is ignored; no queuing.
REQ-021 SHALL: start_ex in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
REQ-022 SHALL: operand inputs are not used after the start cycle; changing them mid-operation does not alter result.

Reset
REQ-023 SHALL: rst=1 at any edge, including mid-operation, forces IDLE, counter 0, busy=0, done=0, result=32'h0.
REQ-024 SHALL: rst takes priority over start_ex in the same cycle; no operation is accepted.

Configuration
REQ-025 SHALL: macro MULDIV_DIV_EN defined: divide datapath, DIV state and ops 4-7 behave per REQ-014..019.
REQ-026 SHALL: macro MULDIV_DIV_EN undefined: no divide logic; ops 4-7 go IDLE->FIX->DONE with result 32'h0, done at k+2; multiply unchanged.

Verification
REQ-027 SHALL: MUL src_a=7, src_b=-3 (32'hFFFF_FFFD) -> done at k+34, result 32'hFFFF_FFEB; stall high k..k+33.
REQ-028 SHALL: MULHU src_a=src_b=32'hFFFF_FFFF -> result 32'hFFFF_FFFE; MULH same operands -> 32'h0000_0000.
REQ-029 SHALL: DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/0 -> 32'hFFFF_FFFF at k+2.
REQ-030 SHALL: DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM same -> 0.
REQ-031 SHALL: start MUL, assert rst at k+10 -> busy=0, done never pulses, result=0; new start at k+12 completes at k+46.
REQ-032 SHALL: start_ex held high through whole op -> exactly one done pulse per accepted op; second op accepted the cycle after DONE.
